// File: rtl/eq_serial_ctrl_pkg.sv
// Shared definitions for the serial nibble-wise equality controller:
// FSM encoding, default geometry and the nibble-index width helper.
package eq_serial_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned NIB       = DEF_WIDTH / 4;

    // Width of a nibble index for a given operand width, never below 1 bit.
    function automatic int unsigned idx_width(input int unsigned width);
        int unsigned n;
        n = width / 4;
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/eq_serial_ctrl_if.sv
// Two-requester compare bus: per-requester req/operands/ack plus shared result.
interface eq_serial_ctrl_if
    import eq_serial_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    localparam int unsigned IDXW = idx_width(WIDTH);

    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             ack0;
    logic             ack1;
    logic             busy;
    logic             done;
    logic             done_id;
    logic             aeqb;
    logic [IDXW-1:0]  mism_idx;

    modport master (
        output req0, req1, a0, b0, a1, b1,
        input  ack0, ack1, busy, done, done_id, aeqb, mism_idx
    );

    modport slave (
        input  req0, req1, a0, b0, a1, b1,
        output ack0, ack1, busy, done, done_id, aeqb, mism_idx
    );

endinterface

// File: rtl/eq_serial_ctrl_eq4_unit.sv
// Single 4-bit equality comparator shared across all nibble positions.
module eq4_unit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       eq
);
    assign eq = (a == b);
endmodule

// File: rtl/eq_serial_ctrl.sv
// Round-robin arbitrated, nibble-serial equality checker with early exit
// on the first mismatching nibble.
module eq_serial_ctrl
    import eq_serial_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input logic            clk,
    input logic            rst_n,
    eq_serial_ctrl_if.slave bus
);
    localparam int unsigned IDXW     = idx_width(WIDTH);
    localparam int unsigned LAST_IDX = WIDTH / 4 - 1;

    state_e           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             done_id_q, done_id_d;
    logic             aeqb_q, aeqb_d;
    logic [IDXW-1:0]  mism_q, mism_d;

    logic             gnt_c;
    logic [3:0]       nib_a_c;
    logic [3:0]       nib_b_c;
    logic             nib_eq_c;

    // Nibble mux feeding the one shared comparator.
    assign nib_a_c = 4'(opa_q >> {idx_q, 2'b00});
    assign nib_b_c = 4'(opb_q >> {idx_q, 2'b00});

    eq4_unit u_eq4 (
        .a  (nib_a_c),
        .b  (nib_b_c),
        .eq (nib_eq_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            aeqb_q    <= 1'b0;
            mism_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            aeqb_q    <= aeqb_d;
            mism_q    <= mism_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        grant_d   = grant_q;
        last_d    = last_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        aeqb_d    = aeqb_q;
        mism_d    = mism_q;
        // On a tie the requester not served last wins.
        gnt_c     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    grant_d = gnt_c;
                    last_d  = gnt_c;
                    opa_d   = gnt_c ? bus.a1 : bus.a0;
                    opb_d   = gnt_c ? bus.b1 : bus.b0;
                    idx_d   = '0;
                    ack0_d  = ~gnt_c;
                    ack1_d  = gnt_c;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (!nib_eq_c) begin
                    aeqb_d    = 1'b0;
                    mism_d    = idx_q;
                    done_d    = 1'b1;
                    done_id_d = grant_q;
                    state_d   = DONE;
                end else if (idx_q == IDXW'(LAST_IDX)) begin
                    aeqb_d    = 1'b1;
                    mism_d    = '0;
                    done_d    = 1'b1;
                    done_id_d = grant_q;
                    state_d   = DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.done_id  = done_id_q;
    assign bus.aeqb     = aeqb_q;
    assign bus.mism_idx = mism_q;

endmodule

// File: tb/tb_eq_serial_ctrl.sv
// Scoreboard bench for eq_serial_ctrl: directed requests push expected
// results; a negedge monitor checks each done against the queue head.
module tb_eq_serial_ctrl;
    import eq_serial_ctrl_pkg::*;

    localparam int unsigned WIDTH = 16;

    typedef struct {
        bit id;
        bit eq;
        int idx;
        int lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    exp_t sb[$];

    eq_serial_ctrl_if #(.WIDTH(WIDTH)) bus ();

    eq_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit id, input bit eq, input int idx, input int lat);
        exp_t e;
        e.id  = id;
        e.eq  = eq;
        e.idx = idx;
        e.lat = lat;
        sb.push_back(e);
    endtask

    // Monitor: tracks the latest ack and checks each done pulse.
    int ack_cyc;
    bit ack_id;
    bit have_res;
    bit held_eq;
    int held_idx;
    initial begin
        ack_cyc  = 0;
        ack_id   = 1'b0;
        have_res = 1'b0;
        held_eq  = 1'b0;
        held_idx = 0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            have_res = 1'b0;
        end else begin
            if (bus.ack0 && bus.ack1)
                check("dual_ack", 1, 0);
            if (bus.ack0 || bus.ack1) begin
                ack_cyc = cyc;
                ack_id  = bus.ack1;
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ack_id",   int'(ack_id),        int'(e.id));
                    check("done_id",  int'(bus.done_id),   int'(e.id));
                    check("aeqb",     int'(bus.aeqb),      int'(e.eq));
                    check("mism_idx", int'(bus.mism_idx),  e.idx);
                    check("latency",  cyc - ack_cyc,       e.lat);
                    have_res = 1'b1;
                    held_eq  = e.eq;
                    held_idx = e.idx;
                end
            end else if (have_res) begin
                check("hold_aeqb", int'(bus.aeqb),     int'(held_eq));
                check("hold_mism", int'(bus.mism_idx), held_idx);
            end
        end
    end

    // Raise a request, hold it until the matching ack, optionally disturb a0 afterwards.
    task automatic req_op(input bit id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit corrupt, output int ack_at);
        ack_at = -1;
        if (id) begin
            bus.a1 = a; bus.b1 = b; bus.req1 = 1'b1;
        end else begin
            bus.a0 = a; bus.b0 = b; bus.req0 = 1'b1;
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (id ? bus.ack1 : bus.ack0) begin
                ack_at = cyc;
                break;
            end
        end
        if (id) bus.req1 = 1'b0;
        else    bus.req0 = 1'b0;
        if (corrupt) bus.a0 = 16'hFFFF;
        if (ack_at < 0) check("ack_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack0"},     int'(bus.ack0),     0);
        check({tag, "_ack1"},     int'(bus.ack1),     0);
        check({tag, "_busy"},     int'(bus.busy),     0);
        check({tag, "_done"},     int'(bus.done),     0);
        check({tag, "_done_id"},  int'(bus.done_id),  0);
        check({tag, "_aeqb"},     int'(bus.aeqb),     0);
        check({tag, "_mism_idx"}, int'(bus.mism_idx), 0);
    endtask

    int t0, t1, tx;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Tie from reset: requester 0 first (full match), then 1 (mismatch at nibble 1).
        push(1'b0, 1'b1, 0, 4);
        push(1'b1, 1'b0, 1, 2);
        fork
            req_op(1'b0, 16'hA5A5, 16'hA5A5, 1'b0, t0);
            req_op(1'b1, 16'h1234, 16'h1204, 1'b0, t1);
        join
        check("ack_spacing", t1 - t0, 6);
        wait_drain();

        // Third tie: requester 1 was served last, so requester 0 wins.
        push(1'b0, 1'b0, 0, 1);
        push(1'b1, 1'b0, 3, 4);
        fork
            req_op(1'b0, 16'h0000, 16'h0001, 1'b0, t0);
            req_op(1'b1, 16'hF000, 16'h0000, 1'b0, t1);
        join
        check("ack_spacing2", t1 - t0, 3);
        wait_drain();

        // Top-nibble mismatch from requester 0.
        push(1'b0, 1'b0, 3, 4);
        req_op(1'b0, 16'hF000, 16'h0000, 1'b0, tx);
        wait_drain();

        // Operand change after ack must not affect the result.
        push(1'b0, 1'b1, 0, 4);
        req_op(1'b0, 16'h5555, 16'h5555, 1'b1, tx);
        wait_drain();

        // Leave done_id=1 and aeqb=1 so the reset clear is observable.
        push(1'b1, 1'b1, 0, 4);
        req_op(1'b1, 16'h0F0F, 16'h0F0F, 1'b0, tx);
        wait_drain();

        // Abort a compare with a one-cycle reset while in CMP.
        req_op(1'b0, 16'hA5A5, 16'hA5A5, 1'b0, tx);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_outputs("post");
        repeat (6) @(posedge clk);
        #1;
        check("idle_after_abort", int'(bus.busy), 0);

        // Normal grant after the abort.
        push(1'b1, 1'b0, 1, 2);
        req_op(1'b1, 16'h1234, 16'h1204, 1'b0, tx);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/eq_serial_ctrl.md
EQ_SERIAL_CTRL -- requirements
Module: eq_serial_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0 / req1  input  1 each  compare request from requester 0 / 1; held high until the matching ack.
REQ-005 a0, b0 / a1, b1  input  WIDTH each  operand pair of requester 0 / 1; stable while the matching req is high.
REQ-006 ack0 / ack1  output  1 each  one-cycle pulse: request granted, operands captured.
REQ-007 busy  output  1  high whenever state is not IDLE.
REQ-008 done  output  1  one-cycle pulse: result valid.
REQ-009 done_id  output  1  requester that owns the current result.
REQ-010 aeqb  output  1  1 = operands equal, 0 = unequal; held until the next done.
REQ-011 mism_idx  output  clog2(WIDTH/4), min 1  index of the first mismatching nibble (LSB nibble = 0); 0 when aeqb=1.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CMP and DONE.
REQ-013 IDLE with any req sampled high: grant one requester, latch its a/b, clear the nibble index to 0, register the matching ack high for the next cycle only, go to CMP.
REQ-014 Arbitration SHALL be round-robin: with both req high, grant the requester not served last; with one req high, grant it.
REQ-015 CMP, each cycle: compare nibble idx of the latched operands through one shared 4-bit equality unit.
REQ-016 CMP, nibble mismatch: register aeqb=0, mism_idx=idx, done=1, done_id=grantee; go to DONE (early exit).
REQ-017 CMP, nibble match with idx = WIDTH/4-1: register aeqb=1, mism_idx=0, done=1; go to DONE.
REQ-018 CMP, nibble match otherwise: idx increments by 1; stay in CMP.
REQ-019 DONE: done SHALL return low; go to IDLE unconditionally; no grant in DONE.
REQ-020 Latency at WIDTH=16: done is high 4 cycles after ack is high for a full match, and n+1 cycles after ack for a first mismatch at nibble n.
REQ-021 Minimum spacing between consecutive acks SHALL be (compare cycles + 2) cycles.
REQ-022 req levels during CMP or DONE SHALL be ignored; a req still high on return to IDLE is arbitrated normally.
REQ-023 aeqb, mism_idx and done_id SHALL hold their values from done until the next done.
REQ-024 The latched operands SHALL be immune to changes on a0/b0/a1/b1 after the ack.

Reset
REQ-025 rst_n low SHALL asynchronously force: state IDLE, ack0=ack1=0, busy=0, done=0, done_id=0, aeqb=0, mism_idx=0, idx=0, last-served pointer=1 (requester 0 wins the first tie).
REQ-026 Reset during CMP or DONE SHALL abort the compare with no done pulse; operation resumes at the first edge after release.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (IDLE, CMP, DONE), the NIB = WIDTH/4 constant and the index-width function.
REQ-028 The 4-bit equality function SHALL be one sub-module, eq4_unit (a[3:0], b[3:0] -> eq), instantiated exactly once and driven by a nibble mux.
REQ-029 Arbiter, FSM, operand registers and result registers SHALL live in eq_serial_ctrl; no other sub-modules.

Verification
REQ-030 req0, a0=16'hA5A5, b0=16'hA5A5 -> ack0 one cycle; done 4 cycles later, aeqb=1, done_id=0, mism_idx=0.
REQ-031 req1, a1=16'h1234, b1=16'h1204 -> ack1; done 2 cycles later, aeqb=0, mism_idx=1, done_id=1.
REQ-032 req0 and req1 high together from reset -> ack0 first; ack1 follows after the first done; the third tie goes to requester 0.
REQ-033 a0=16'h0000, b0=16'h0001 -> done 1 cycle after ack, mism_idx=0; a0=16'hF000, b0=16'h0000 -> done 4 cycles after ack, mism_idx=3.
REQ-034 Change a0 to 16'hFFFF in the cycle after ack0 of a 16'h5555/16'h5555 compare -> aeqb=1 (latched operands used).
REQ-035 rst_n low for 1 cycle during CMP -> no done pulse, all outputs at reset values, busy=0; next req is granted normally.
